// File: rtl/result_ring.sv
// result_ring: circular history of the most recent results, read by relative slot.
// Slot k>=1 returns the entry written k writes ago; slot 0 optionally forwards the
// same-cycle write. A rewind discards the newest entries without touching storage.

// One read port: a private copy of the storage, written like every other copy, plus its read mux.
module result_ring_port #(
  parameter int DATA_W = 32,
  parameter int SLOT_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              mem_we,
  input  logic [SLOT_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] write,
  input  logic              we,
  input  logic [SLOT_W-1:0] slot,
  input  logic [SLOT_W-1:0] wp,
  input  logic [SLOT_W:0]   fill,
  output logic [DATA_W-1:0] read,
  output logic              read_valid
);
  localparam int D = 2 ** SLOT_W;

  logic [DATA_W-1:0] mem [D];
  logic [SLOT_W-1:0] raddr;

  assign raddr = wp - slot;

  // Storage copy: no reset, single write port, asynchronous read.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= write;
  end

  // Read mux: slot 0 is the bypass slot, others are live only up to fill.
  always_comb begin
    read       = '0;
    read_valid = 1'b0;
    if (slot == '0) begin
      if (BYPASS != 0 && we) begin
        read       = write;
        read_valid = 1'b1;
      end
    end else if ({1'b0, slot} <= fill) begin
      read       = mem[raddr];
      read_valid = 1'b1;
    end
  end
endmodule

module result_ring #(
  parameter int DATA_W = 32,
  parameter int SLOT_W = 5,
  parameter int N_READ = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [DATA_W-1:0]        write,
  input  logic [N_READ*SLOT_W-1:0] slot,
  output logic [N_READ*DATA_W-1:0] read,
  output logic [N_READ-1:0]        read_valid,
  input  logic                     rewind,
  input  logic [SLOT_W-1:0]        rewind_count,
  output logic [SLOT_W-1:0]        write_addr,
  output logic [SLOT_W:0]          fill,
  output logic [DATA_W-1:0]        last_data
);
  localparam int D = 2 ** SLOT_W;
  localparam logic [SLOT_W:0] DEPTH = (SLOT_W+1)'(D);

  logic [SLOT_W-1:0] wp;
  logic [SLOT_W:0]   fill_q;
  logic [DATA_W-1:0] last_q;
  logic [SLOT_W:0]   r_amt;
  logic [SLOT_W-1:0] wp_base;
  logic [SLOT_W:0]   fill_base;
  logic [SLOT_W:0]   fill_nxt;
  logic              mem_we;

  // Rewind amount is clamped to the live count, so an empty ring never moves.
  // rewind_count tops out at D-1, so r_amt always fits back into a slot index.
  always_comb begin
    r_amt = '0;
    if (rewind) r_amt = ({1'b0, rewind_count} < fill_q) ? {1'b0, rewind_count} : fill_q;
  end

  // Rewind is applied first; a same-cycle write lands on the rewound pointer.
  assign wp_base   = wp - r_amt[SLOT_W-1:0];
  assign fill_base = fill_q - r_amt;
  assign fill_nxt  = !we ? fill_base : (fill_base == DEPTH) ? DEPTH : fill_base + 1'b1;
  assign mem_we    = we & reset_n;

  // Pointer, occupancy and last-value state; reset wins over write and rewind.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wp     <= '0;
      fill_q <= '0;
      last_q <= '0;
    end else begin
      wp     <= we ? wp_base + 1'b1 : wp_base;
      fill_q <= fill_nxt;
      if (we) last_q <= write;
    end
  end

  assign write_addr = wp;
  assign fill       = fill_q;
  assign last_data  = last_q;

  genvar i;
  generate
    for (i = 0; i < N_READ; i++) begin : g_port
      result_ring_port #(
        .DATA_W(DATA_W),
        .SLOT_W(SLOT_W),
        .BYPASS(BYPASS)
      ) u_port (
        .clock      (clock),
        .mem_we     (mem_we),
        .mem_waddr  (wp_base),
        .write      (write),
        .we         (we),
        .slot       (slot[i*SLOT_W +: SLOT_W]),
        .wp         (wp),
        .fill       (fill_q),
        .read       (read[i*DATA_W +: DATA_W]),
        .read_valid (read_valid[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_result_ring.sv
// Scoreboard bench for result_ring: stimulus predicts outputs from a queue-based
// history model, a negedge monitor pops and compares against the DUT.
module tb_result_ring;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int NR = 2;
  localparam int D  = 32;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             we;
  logic [DW-1:0]    write;
  logic [NR*SW-1:0] slot;
  logic [NR*DW-1:0] read;
  logic [NR-1:0]    read_valid;
  logic             rewind;
  logic [SW-1:0]    rewind_count;
  logic [SW-1:0]    write_addr;
  logic [SW:0]      fill;
  logic [DW-1:0]    last_data;

  always #5 clock = ~clock;

  result_ring #(.DATA_W(DW), .SLOT_W(SW), .N_READ(NR), .BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n), .we(we), .write(write), .slot(slot),
    .read(read), .read_valid(read_valid), .rewind(rewind),
    .rewind_count(rewind_count), .write_addr(write_addr), .fill(fill),
    .last_data(last_data)
  );

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rv;
    logic [SW:0]      fl;
    logic [SW-1:0]    wa;
    logic [DW-1:0]    last;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] hist[$];   // live entries, oldest first
  int            wp_m = 0;
  logic [DW-1:0] last_m = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational outputs from the model state plus current inputs.
  function automatic exp_t predict();
    exp_t e;
    e.rd = '0; e.rv = '0;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = int'(slot[i*SW +: SW]);
      if (k == 0) begin
        if (we) begin e.rv[i] = 1'b1; e.rd[i*DW +: DW] = write; end
      end else if (k <= hist.size()) begin
        e.rv[i] = 1'b1;
        e.rd[i*DW +: DW] = hist[hist.size() - k];
      end
    end
    e.fl = (SW+1)'(hist.size());
    e.wa = SW'(wp_m);
    e.last = last_m;
    return e;
  endfunction

  task automatic step(input bit w, input logic [DW-1:0] d, input bit rw, input int rc,
                      input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                      input bit rst, input bit chk);
    reset_n = !rst; we = w; write = d; rewind = rw;
    rewind_count = SW'(rc); slot = {s1, s0};
    if (chk) sb.push_back(predict());
    @(posedge clock);
    if (rst) begin
      hist.delete(); wp_m = 0; last_m = '0;
    end else begin
      if (rw) begin
        int r;
        r = (rc < hist.size()) ? rc : hist.size();
        repeat (r) void'(hist.pop_back());
        wp_m = (wp_m - r + D) % D;
      end
      if (w) begin
        hist.push_back(d);
        if (hist.size() > D) void'(hist.pop_front());
        wp_m = (wp_m + 1) % D;
        last_m = d;
      end
    end
    #1;
  endtask

  task automatic peek(input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    reset_n = 1'b1; we = 1'b0; rewind = 1'b0; slot = {s1, s0};
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: outputs are always presented, so compare each pending prediction mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_read", 64'(read), 64'(e.rd));
      check("sb_valid", 64'(read_valid), 64'(e.rv));
      check("sb_fill", 64'(fill), 64'(e.fl));
      check("sb_waddr", 64'(write_addr), 64'(e.wa));
      check("sb_last", 64'(last_data), 64'(e.last));
    end
  end

  initial begin
    do_reset();
    do_reset();
    peek(1, 7);
    check("rst_fill", 64'(fill), 0);
    check("rst_valid", 64'(read_valid), 0);

    // Three writes, read back newest and oldest.
    step(1, 32'h11, 0, 0, 0, 1, 0, 1);
    step(1, 32'h22, 0, 0, 1, 0, 0, 1);
    step(1, 32'h33, 0, 0, 1, 2, 0, 1);
    peek(1, 3);
    check("d37_rd0", 64'(read[DW-1:0]), 64'h33);
    check("d37_rd1", 64'(read[2*DW-1:DW]), 64'h11);
    check("d37_vld", 64'(read_valid), 64'h3);
    check("d37_fill", 64'(fill), 3);
    check("d37_waddr", 64'(write_addr), 3);
    check("d37_last", 64'(last_data), 64'h33);
    peek(4, 4);
    check("d38_vld", 64'(read_valid), 0);
    check("d38_rd", 64'(read), 0);
    we = 1'b1; write = 32'h44; slot = '0; #1;
    check("d38_byp_rd", 64'(read[DW-1:0]), 64'h44);
    check("d38_byp_vld", 64'(read_valid[0]), 1);
    step(1, 32'h44, 0, 0, 0, 4, 0, 1);

    // Wrap: D+2 writes.
    do_reset();
    for (int v = 1; v <= D + 2; v++) step(1, DW'(v), 0, 0, 1, SW'(v % D), 0, 1);
    peek(1, 0);
    check("d39_fill", 64'(fill), 32);
    check("d39_waddr", 64'(write_addr), 2);
    check("d39_s1", 64'(read[DW-1:0]), 34);
    slot = {5'd0, 5'd0}; slot[SW-1:0] = 5'd0;
    reset_n = 1'b1; slot = {SW'(0), SW'(0)}; #1;
    // slot 32 is not expressible in SW bits when D=32; oldest live is slot 31 -> value 4.
    peek(31, 1);
    check("d39_oldest", 64'(read[DW-1:0]), 4);

    // Rewind alone.
    do_reset();
    for (int v = 1; v <= 5; v++) step(1, DW'(v), 0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 2, 1, 3, 0, 1);
    peek(1, 4);
    check("d40_fill", 64'(fill), 3);
    check("d40_s1", 64'(read[DW-1:0]), 3);
    check("d40_last", 64'(last_data), 5);
    check("d40_vld", 64'(read_valid), 64'h1);
    step(0, 0, 1, 9, 1, 2, 0, 1);
    peek(1, 2);
    check("d40b_fill", 64'(fill), 0);
    check("d40b_waddr", 64'(write_addr), 0);
    check("d40b_vld", 64'(read_valid), 0);
    step(0, 0, 1, 3, 1, 0, 0, 1);
    peek(1, 0);
    check("d40c_empty_rw", 64'(write_addr), 0);

    // Rewind with a simultaneous write.
    do_reset();
    for (int v = 1; v <= 4; v++) step(1, DW'(32'h100 + v), 0, 0, 0, 0, 0, 1);
    step(1, 32'hAA, 1, 2, 0, 2, 0, 1);
    peek(1, 2);
    check("d41_fill", 64'(fill), 3);
    check("d41_waddr", 64'(write_addr), 3);
    check("d41_s1", 64'(read[DW-1:0]), 64'hAA);
    check("d41_s2", 64'(read[2*DW-1:DW]), 64'h102);

    // Reset mid-sequence with a write pending.
    for (int v = 1; v <= 6; v++) step(1, DW'(v), 0, 0, 0, 0, 0, 1);
    step(1, 32'h55, 0, 0, 1, 2, 1, 1);
    peek(1, 6);
    check("d42_fill", 64'(fill), 0);
    check("d42_waddr", 64'(write_addr), 0);
    check("d42_last", 64'(last_data), 0);
    check("d42_vld", 64'(read_valid), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit w, rw, rst;
      logic [SW-1:0] s0, s1;
      w   = ($urandom_range(0, 99) < 65);
      rw  = ($urandom_range(0, 99) < 12);
      rst = ($urandom_range(0, 299) == 0);
      s0  = ($urandom_range(0, 3) == 0) ? SW'(0) : SW'($urandom_range(0, D - 1));
      s1  = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, 6)) : SW'($urandom_range(0, D - 1));
      step(w, $urandom, rw, int'($urandom_range(0, D - 1)), s0, s1, rst, 1);
    end

    repeat (3) @(posedge clock);
    check("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_ring.md
RESULT_RING -- requirements
Module: result_ring

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of each stored result.
REQ-002 SHALL have parameter SLOT_W, default 5, the slot index width; depth D = 2**SLOT_W.
REQ-003 SHALL have parameter N_READ, default 2, the number of independent read ports.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, slot 0 forwards the same-cycle write.
REQ-005 clock  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-007 we  in  1  push `write` into the ring this cycle.
REQ-008 write  in  DATA_W  result to push.
REQ-009 slot  in  N_READ*SLOT_W  per-port relative index; port i uses bits [i*SLOT_W +: SLOT_W].
REQ-010 read  out  N_READ*DATA_W  per-port read data, packed the same way as `slot`.
REQ-011 read_valid  out  N_READ  per-port flag: the slot refers to a live entry.
REQ-012 rewind  in  1  discard the newest entries this cycle.
REQ-013 rewind_count  in  SLOT_W  number of entries to discard when rewind=1.
REQ-014 write_addr  out  SLOT_W  physical index of the next write (wp).
REQ-015 fill  out  SLOT_W+1  number of live entries, range 0..D.
REQ-016 last_data  out  DATA_W  value of the most recent accepted write.

Function
REQ-017 Slot k (k >= 1) SHALL address the entry written k writes ago, at physical address (wp - k) mod D (SLOT_W-bit wrap).
REQ-018 Reads SHALL be combinational from the current wp, fill, slot and storage, with zero-cycle latency; each port is independent and ports may request the same slot.
REQ-019 For 1 <= k <= fill: read_valid[i]=1 and read[i] = the stored entry.
REQ-020 For k > fill: read_valid[i]=0 and read[i]=0.
REQ-021 With BYPASS=1 and k=0: read_valid[i]=we and read[i] = (we ? write : 0).
REQ-022 With BYPASS=0 and k=0: read_valid[i]=0 and read[i]=0.
REQ-023 A write is not visible through slots >= 1 until the cycle after it is accepted.
REQ-024 Write with rewind=0: store `write` at wp; wp <= wp+1 mod D; fill <= min(fill+1, D); last_data <= write.
REQ-025 On wrap with fill = D, the oldest entry is overwritten and fill stays at D.
REQ-026 Rewind: let r = min(rewind_count, fill); wp <= wp - r mod D; fill <= fill - r; storage is not modified.
REQ-027 Simultaneous rewind and we: the rewind applies first; the write lands at wp - r; wp <= wp - r + 1; fill <= min(fill - r + 1, D); last_data <= write.
REQ-028 A rewind alone SHALL NOT change last_data.
REQ-029 rewind with rewind_count=0 SHALL be a no-op.
REQ-030 A rewind while fill=0 SHALL leave wp and fill unchanged.
REQ-031 Storage SHALL be inferable as N_READ copies of a 1-write/1-read memory (MLAB style), all written identically.
REQ-032 No reset is required on storage contents.

Reset
REQ-033 When reset_n=0 at a rising edge: wp <= 0, fill <= 0, last_data <= 0.
REQ-034 When reset_n=0 at a rising edge, any we or rewind in the same cycle SHALL be ignored.
REQ-035 After reset, every read_valid SHALL be 0 for all k >= 1 until writes occur.
REQ-036 Reset asserted mid-sequence SHALL discard all live entries; old contents SHALL NOT become visible again, since fill=0.

Verification
REQ-037 Reset, then write 0x11, 0x22, 0x33 on consecutive cycles; set slot0=1, slot1=3 -> read = 0x33 / 0x11, both valid; fill=3; write_addr=3; last_data=0x33.
REQ-038 After 3 writes, request slot=4 -> read_valid=0 and read=0; with BYPASS=1, we=1, write=0x44 and slot=0 -> read=0x44, valid=1 in that same cycle.
REQ-039 Write D+2 values 1..D+2 (default D=32) -> fill=32, write_addr=2; slot=1 -> 34; slot=32 -> 3.
REQ-040 After 5 writes (values 1..5), rewind with rewind_count=2 -> fill=3, slot=1 -> 3, last_data=5; rewind with rewind_count=9 -> fill=0, wp=0, all read_valid=0.
REQ-041 After 4 writes, rewind with rewind_count=2 and we=1, write=0xAA in the same cycle -> fill=3, write_addr=3, slot=1 -> 0xAA, slot=2 -> 2nd write.
REQ-042 After 6 writes, assert reset_n=0 for one cycle with we=1 -> fill=0, write_addr=0, last_data=0; no entry readable.
